// File: rtl/ysyx_25060170_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25060170_pkg
// Shared definitions for the ysyx_25060170 multi-cycle sequencer:
//   - seq_state_e     : sequencer state encoding (also exported on state_o)
//   - TIMEOUT_DEFAULT : default handshake wait limit in cycles
//   - cnt_width()     : bits needed to hold a wait count up to a given limit
// ---------------------------------------------------------------------------
package ysyx_25060170_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } seq_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ysyx_25060170_wait_cnt.sv
// ---------------------------------------------------------------------------
// ysyx_25060170_wait_cnt
// Clearable saturating wait counter with a limit flag. Counts the cycles a
// handshake has been waiting; 'last' marks the LIMIT-th waiting cycle, i.e.
// the final cycle in which a valid may still arrive before a timeout.
//
// Parameters:
//   LIMIT : number of waiting cycles allowed (>= 1)
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  synchronous active-high reset
//   clr   in  1  synchronous clear (held while not waiting)
//   en    in  1  count this cycle as a waiting cycle
//   last  out 1  this waiting cycle is the LIMIT-th one
// ---------------------------------------------------------------------------
module ysyx_25060170_wait_cnt
    import ysyx_25060170_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int unsigned W        = cnt_width(LIMIT);
    localparam int unsigned LAST_IDX = (LIMIT > 0) ? LIMIT - 1 : 0;
    localparam logic [W-1:0] CNT_LAST = W'(LAST_IDX);
    localparam logic [W-1:0] CNT_MAX  = W'(LIMIT);

    logic [W-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end
    end

    // count holds the number of waiting cycles already elapsed, so the
    // current cycle is the LIMIT-th one when count == LIMIT-1.
    assign last = en && (count >= CNT_LAST);

endmodule

// File: rtl/ysyx_25060170_seq.sv
// ---------------------------------------------------------------------------
// ysyx_25060170_seq
// Multi-cycle processor sequencer: IDLE -> FETCH -> DECODE -> EXEC ->
// [MEM] -> WB -> FETCH ..., with absorbing HALT (ebreak) and ERR (handshake
// timeout) states. All outputs are Moore-decoded from the state register.
//
// Configuration macro:
//   YSYX_25060170_SEQ_PERF_EN  defined   -> cycle/instret counters present
//                              undefined -> cycle_o and instret_o tied to 0
//
// Parameters:
//   TIMEOUT      max waiting cycles in FETCH or MEM before ERR
// Ports:
//   clk          in   1  clock, rising edge
//   rst          in   1  synchronous active-high reset
//   run_i        in   1  start permission, sampled in IDLE
//   ifu_valid_i  in   1  fetched instruction available (FETCH)
//   is_mem_i     in   1  instruction is load/store (sampled in DECODE)
//   ebreak_i     in   1  instruction is ebreak (sampled in DECODE)
//   lsu_valid_i  in   1  memory access complete (MEM)
//   ifu_req_o    out  1  fetch request
//   idu_en_o     out  1  decode register enable
//   exu_en_o     out  1  EXU result register enable
//   lsu_req_o    out  1  memory request
//   wb_en_o      out  1  register-file write enable
//   pc_we_o      out  1  PC update strobe
//   halt_o       out  1  ebreak reached (sticky until rst)
//   err_o        out  1  handshake timeout (sticky until rst)
//   state_o      out  3  current state encoding
//   cycle_o      out 32  cycles spent outside IDLE/HALT/ERR
//   instret_o    out 32  retired instruction count
// ---------------------------------------------------------------------------
module ysyx_25060170_seq
    import ysyx_25060170_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_i,
    input  logic        ifu_valid_i,
    input  logic        is_mem_i,
    input  logic        ebreak_i,
    input  logic        lsu_valid_i,
    output logic        ifu_req_o,
    output logic        idu_en_o,
    output logic        exu_en_o,
    output logic        lsu_req_o,
    output logic        wb_en_o,
    output logic        pc_we_o,
    output logic        halt_o,
    output logic        err_o,
    output logic [2:0]  state_o,
    output logic [31:0] cycle_o,
    output logic [31:0] instret_o
);

    seq_state_e state_q;
    seq_state_e state_d;
    logic       mem_q;      // is_mem_i captured in DECODE, consumed in EXEC
    logic       waiting;
    logic       wait_last;

    // ------------------------------------------------------------------
    // State register and decode-time capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mem_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                mem_q <= is_mem_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake timeout. The counter is held clear in every non-waiting
    // state, which clears it on entry to both FETCH and MEM.
    // ------------------------------------------------------------------
    assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);

    ysyx_25060170_wait_cnt #(
        .LIMIT (TIMEOUT)
    ) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (!waiting),
        .en   (waiting),
        .last (wait_last)
    );

    // ------------------------------------------------------------------
    // Next-state logic. A valid arriving on the last allowed waiting cycle
    // is tested first, so it wins over the timeout.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: a default at the top of every always_comb guarantees each path
        // assigns the variable, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (run_i) state_d = ST_FETCH;
            ST_FETCH: begin
                if (ifu_valid_i)    state_d = ST_DECODE;
                else if (wait_last) state_d = ST_ERR;
            end
            ST_DECODE: state_d = ebreak_i ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_d = mem_q ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (lsu_valid_i)    state_d = ST_WB;
                else if (wait_last) state_d = ST_ERR;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign ifu_req_o = (state_q == ST_FETCH);
    assign idu_en_o  = (state_q == ST_DECODE);
    assign exu_en_o  = (state_q == ST_EXEC);
    assign lsu_req_o = (state_q == ST_MEM);
    assign wb_en_o   = (state_q == ST_WB);
    assign pc_we_o   = (state_q == ST_WB);
    assign halt_o    = (state_q == ST_HALT);
    assign err_o     = (state_q == ST_ERR);
    assign state_o   = state_q;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef YSYX_25060170_SEQ_PERF_EN
    logic [31:0] cycle_q;
    logic [31:0] instret_q;
    logic        active;

    assign active = (state_q != ST_IDLE) && (state_q != ST_HALT) &&
                    (state_q != ST_ERR);

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (active) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (state_q == ST_WB) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign cycle_o   = cycle_q;
    assign instret_o = instret_q;
`else
    assign cycle_o   = '0;
    assign instret_o = '0;
`endif

endmodule
